// File: rtl/ssd_pkg.sv
// ssd_pkg: character codes and active-low glyphs shared by the
// lock FSM and the display scan driver.
package ssd_pkg;

  localparam int NDIG   = 4;
  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [6:0]        seg_t;

  localparam code_t CODE_C     = 5'd10;
  localparam code_t CODE_L     = 5'd11;
  localparam code_t CODE_S     = 5'd12;
  localparam code_t CODE_D     = 5'd13;
  localparam code_t CODE_O     = 5'd14;
  localparam code_t CODE_P     = 5'd15;
  localparam code_t CODE_E     = 5'd16;
  localparam code_t CODE_N     = 5'd17;
  localparam code_t CODE_TIRE  = 5'd18;
  localparam code_t CODE_BLANK = 5'd19;

  // {a,b,c,d,e,f,g}, 0 = segment lit
  localparam seg_t SEG_0     = 7'h01;
  localparam seg_t SEG_1     = 7'h4F;
  localparam seg_t SEG_2     = 7'h12;
  localparam seg_t SEG_3     = 7'h06;
  localparam seg_t SEG_4     = 7'h4C;
  localparam seg_t SEG_5     = 7'h24;
  localparam seg_t SEG_6     = 7'h20;
  localparam seg_t SEG_7     = 7'h0F;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h04;
  localparam seg_t SEG_C     = 7'h31;
  localparam seg_t SEG_L     = 7'h71;
  localparam seg_t SEG_D     = 7'h42;
  localparam seg_t SEG_P     = 7'h18;
  localparam seg_t SEG_E     = 7'h30;
  localparam seg_t SEG_N     = 7'h6A;
  localparam seg_t SEG_TIRE  = 7'h7E;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: character word in, multiplexed anode and
// segment drive out.
interface ssd_scan_driver_if;
  import ssd_pkg::*;

  logic [19:0] ssd;
  logic [3:0]  blink_mask;
  logic [3:0]  AN;
  seg_t        seven_out;
  logic        frame_start;

  modport master (
    output ssd, blink_mask,
    input  AN, seven_out, frame_start
  );

  modport slave (
    input  ssd, blink_mask,
    output AN, seven_out, frame_start
  );

endinterface

// File: rtl/ssd_decode.sv
// ssd_decode: 5-bit character code to active-low segments.
// Unassigned codes render blank.
module ssd_decode
  import ssd_pkg::*;
(
  input  code_t code_i,
  output seg_t  seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      5'd0:      seg_o = SEG_0;
      5'd1:      seg_o = SEG_1;
      5'd2:      seg_o = SEG_2;
      5'd3:      seg_o = SEG_3;
      5'd4:      seg_o = SEG_4;
      5'd5:      seg_o = SEG_5;
      5'd6:      seg_o = SEG_6;
      5'd7:      seg_o = SEG_7;
      5'd8:      seg_o = SEG_8;
      5'd9:      seg_o = SEG_9;
      CODE_C:    seg_o = SEG_C;
      CODE_L:    seg_o = SEG_L;
      CODE_S:    seg_o = SEG_5;
      CODE_D:    seg_o = SEG_D;
      CODE_O:    seg_o = SEG_0;
      CODE_P:    seg_o = SEG_P;
      CODE_E:    seg_o = SEG_E;
      CODE_N:    seg_o = SEG_N;
      CODE_TIRE: seg_o = SEG_TIRE;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: 4-digit common-anode scan with per-frame shadow
// latch; optional digit blinking when SSD_BLINK_EN is defined.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 1
)(
  input logic               clk,
  input logic               rst,
  ssd_scan_driver_if.slave  bus
);

  localparam int DWELL = CLK_HZ / (4 * REFRESH_HZ);
  localparam int DW_W  = $clog2(DWELL);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      idx_q, idx_d;
  logic [19:0]     shadow_q, shadow_d;
  logic            first_q;
  logic [3:0]      an_q, an_d;
  seg_t            seg_q, seg_d;
  logic            fs_q;

  logic  dwell_end;
  logic  load;
  logic  blank;
  code_t code;
  seg_t  seg_dec;

  assign dwell_end = (dwell_q == DW_LAST);
  assign load = first_q | (dwell_end & (idx_q == 2'd3));

  always_comb begin
    dwell_d  = dwell_q + DW_W'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (dwell_end) begin
      dwell_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    if (load) shadow_d = bus.ssd;
  end

  always_comb begin
    code = shadow_q[19:15];
    case (idx_q)
      2'd0: code = shadow_q[19:15];
      2'd1: code = shadow_q[14:10];
      2'd2: code = shadow_q[9:5];
      2'd3: code = shadow_q[4:0];
      default: code = shadow_q[19:15];
    endcase
  end

  ssd_decode u_dec (
    .code_i (code),
    .seg_o  (seg_dec)
  );

`ifdef SSD_BLINK_EN
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          boff_q, boff_d;
  logic [3:0]    mask_q, mask_d;

  // Blink phase free-runs; it is not aligned to frames.
  always_comb begin
    bcnt_d = bcnt_q + BW'(1);
    boff_d = boff_q;
    mask_d = mask_q;
    if (bcnt_q == B_LAST) begin
      bcnt_d = '0;
      boff_d = ~boff_q;
    end
    if (load) mask_d = bus.blink_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      boff_q <= 1'b0;
      mask_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      boff_q <= boff_d;
      mask_q <= mask_d;
    end
  end

  assign blank = boff_q & mask_q[~idx_q];
`else
  logic unused_mask;
  assign unused_mask = ^bus.blink_mask;
  assign blank = 1'b0;
`endif

  assign an_d  = ~(4'b1000 >> idx_q);
  assign seg_d = blank ? SEG_BLANK : seg_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q  <= '0;
      idx_q    <= '0;
      shadow_q <= {NDIG{CODE_BLANK}};
      first_q  <= 1'b1;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
      fs_q     <= 1'b0;
    end else begin
      dwell_q  <= dwell_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      first_q  <= 1'b0;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= load;
    end
  end

  assign bus.AN          = an_q;
  assign bus.seven_out   = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed scan/decode/tearing/blink/reset
// checks against an arithmetic model of the display schedule.
module tb_ssd_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (50),
    .BLINK_HZ   (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] tab [32];
  int         k;
  logic [4:0] sh [4];
  logic [3:0] msk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) sh[i] = 5'd19;
    msk = 4'b0000;
  endtask

  // Edge k after release shows digit ((k-1)/5)%4 from the word
  // latched at an earlier edge; latches happen at k=1 and k%20==0.
  task automatic tick();
    int         pos;
    bit         boff;
    bit         lat;
    logic [3:0] ean;
    logic [6:0] eseg;
    if (!rst) begin
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_an", bus.AN, 4'b1111);
      chk("rst_seg", bus.seven_out, 7'h7F);
      chk("rst_fs", bus.frame_start, 1'b0);
      return;
    end
    k++;
    pos  = ((k - 1) / 5) % 4;
    boff = (((k - 1) / 50) % 2) == 1;
    lat  = (k == 1) || (k % 20 == 0);
    ean  = ~(4'b1000 >> pos);
    eseg = tab[sh[pos]];
`ifdef SSD_BLINK_EN
    if (boff && msk[3 - pos]) eseg = 7'h7F;
`endif
    if (lat) begin
      sh[0] = bus.ssd[19:15];
      sh[1] = bus.ssd[14:10];
      sh[2] = bus.ssd[9:5];
      sh[3] = bus.ssd[4:0];
      msk   = bus.blink_mask;
    end
    @(posedge clk);
    #1;
    chk("an", bus.AN, ean);
    chk("seg", bus.seven_out, eseg);
    chk("fs", bus.frame_start, lat);
  endtask

  task automatic run_to(int kk);
    while (k < kk) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tab[i] = 7'h7F;
    tab[0]  = 7'h01; tab[1]  = 7'h4F; tab[2]  = 7'h12; tab[3]  = 7'h06;
    tab[4]  = 7'h4C; tab[5]  = 7'h24; tab[6]  = 7'h20; tab[7]  = 7'h0F;
    tab[8]  = 7'h00; tab[9]  = 7'h04; tab[10] = 7'h31; tab[11] = 7'h71;
    tab[12] = 7'h24; tab[13] = 7'h42; tab[14] = 7'h01; tab[15] = 7'h18;
    tab[16] = 7'h30; tab[17] = 7'h6A; tab[18] = 7'h7E;
    model_reset();

    bus.ssd        = {5'd10, 5'd11, 5'd12, 5'd13};
    bus.blink_mask = 4'b0000;
    #2 rst = 1'b0;
    #1;
    chk("lit_rst_an", bus.AN, 4'b1111);
    chk("lit_rst_seg", bus.seven_out, 7'h7F);
    repeat (3) tick();
    rst = 1'b1;

    tick();
    chk("lit_first_fs", bus.frame_start, 1'b1);
    chk("lit_first_an", bus.AN, 4'b0111);
    run_to(3);
    chk("lit_C", bus.seven_out, 7'h31);
    run_to(8);
    chk("lit_L_an", bus.AN, 4'b1011);
    chk("lit_L", bus.seven_out, 7'h71);
    run_to(13);
    chk("lit_S", bus.seven_out, 7'h24);
    run_to(18);
    chk("lit_d_an", bus.AN, 4'b1110);
    chk("lit_d", bus.seven_out, 7'h42);

    bus.ssd = {5'd14, 5'd15, 5'd16, 5'd17};
    run_to(26);
    bus.ssd = {5'd1, 5'd2, 5'd3, 5'd4};
    run_to(28);
    chk("lit_tear_P", bus.seven_out, 7'h18);
    run_to(33);
    chk("lit_tear_E", bus.seven_out, 7'h30);
    run_to(38);
    chk("lit_tear_n", bus.seven_out, 7'h6A);
    run_to(43);
    chk("lit_1", bus.seven_out, 7'h4F);
    run_to(48);
    chk("lit_2", bus.seven_out, 7'h12);
    run_to(53);
    chk("lit_3", bus.seven_out, 7'h06);
    run_to(58);
    chk("lit_4", bus.seven_out, 7'h4C);

    bus.ssd        = {5'd0, 5'd18, 5'd19, 5'd19};
    bus.blink_mask = 4'b1000;
    run_to(63);
`ifdef SSD_BLINK_EN
    chk("lit_blink_off", bus.seven_out, 7'h7F);
`else
    chk("lit_noblink", bus.seven_out, 7'h01);
`endif
    run_to(68);
    chk("lit_dash", bus.seven_out, 7'h7E);
    run_to(103);
    chk("lit_blink_on", bus.seven_out, 7'h01);
    run_to(163);
`ifdef SSD_BLINK_EN
    chk("lit_blink_off2", bus.seven_out, 7'h7F);
`else
    chk("lit_noblink2", bus.seven_out, 7'h01);
`endif
    run_to(171);

    rst = 1'b0;
    #1;
    chk("lit_mid_an", bus.AN, 4'b1111);
    chk("lit_mid_seg", bus.seven_out, 7'h7F);
    chk("lit_mid_fs", bus.frame_start, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("lit_re_an", bus.AN, 4'b0111);
    chk("lit_re_fs", bus.frame_start, 1'b1);
    tick();
    chk("lit_re_seg", bus.seven_out, 7'h01);
    run_to(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

- Downstream stage of the lock controller FSM.
- Consumes its registered 20-bit `ssd` word: four 5-bit character codes, leftmost first.
- Time-multiplexes the four characters onto the board's common-anode 4-digit display.
- Each frame, latches the word into a shadow register to avoid tearing, decodes codes to segments, and optionally blinks selected digits at a slow rate for the "enter digit" states.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `REFRESH_HZ`, default 1000: full-frame (4-digit) refresh rate. Dwell per digit `DWELL = CLK_HZ/(4*REFRESH_HZ)` cycles, must be ≥2.
- `BLINK_HZ`, default 1: blink rate. Half-period `BLINK_HALF = CLK_HZ/(2*BLINK_HZ)` cycles.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ssd` in 20: character codes. `[19:15]` is the leftmost digit and `[4:0]` the rightmost.
- `blink_mask` in 4: bit3 = leftmost digit; 1 = blink this digit.
- `AN` out 4: anodes, active-low. `AN[3]` is the leftmost digit.
- `seven_out` out 7: segments `{a,b,c,d,e,f,g}`, active-low (0 = lit).
- `frame_start` out 1: one-cycle pulse when the shadow register loads.

## Operation
- Code map:
  - 0–9: decimal digits.
  - 10: C.
  - 11: L.
  - 12: S (pattern of 5).
  - 13: d.
  - 14: O (pattern of 0).
  - 15: P.
  - 16: E.
  - 17: n.
  - 18: dash (g only).
  - 19: blank.
  - 20–31: blank.
- Counters:
  - `dwell_cnt` counts 0..DWELL-1.
  - At terminal count it wraps and `idx` (0..3) increments, wrapping 3→0.
  - `idx` 0 selects the leftmost digit (`AN=4'b0111`, `shadow[19:15]`), …, `idx` 3 selects the rightmost (`AN=4'b1110`, `shadow[4:0]`).
- Frame latch:
  - When `idx==3` and `dwell_cnt==DWELL-1`, `shadow<=ssd`, `mask_sh<=blink_mask`, and `frame_start` pulses the same cycle.
  - Mid-frame input changes are invisible until the next latch.
- Output register:
  - `AN` and `seven_out` are registered from the current `idx`, `shadow` and blink phase.
  - Exactly one anode is low at any time after the first post-reset cycle.
- Blink:
  - `blink_cnt` counts 0..BLINK_HALF-1 and toggles `blink_off` at wrap.
  - While `blink_off==1` and `mask_sh` has the bit for the current digit set, `seven_out=7'h7F`. The anode is still driven.
- Reset (`rst` low), immediately and asynchronously:
  - `AN=4'b1111`, `seven_out=7'h7F`, `frame_start=0`.
  - `dwell_cnt=0`, `idx=0`, `blink_cnt=0`, `blink_off=0`.
  - `shadow` = four blank codes (`{5'd19 x4}`), `mask_sh=0`.
- Post-reset load: `shadow` loads unconditionally on the first rising edge after `rst` rises. `frame_start` pulses that cycle.

## Timing
- Outputs lag `idx`/`dwell_cnt` by one cycle; each digit is displayed for exactly DWELL cycles.
- Input-to-display latency: a word stable before a latch edge appears on the leftmost digit 1 cycle after that edge, and completes after DWELL*4 more cycles.
- `blink_off` changes exactly every BLINK_HALF cycles, independent of frame phase.
- Simultaneous latch and blink toggle: both take effect on the same edge; the next output uses the new mask and new phase.
- Reset asserted mid-frame: the in-progress frame is abandoned. The display restarts at `idx` 0 with the blink phase on.

## Configuration
- `SSD_BLINK_EN` defined:
  - Blink counter, `blink_off` and `mask_sh` are present and behave as above.
- Undefined:
  - Blink logic is not compiled. The `blink_mask` port remains and is ignored.
  - `seven_out` depends only on the decoded code.

## Structure
- Package `ssd_pkg`:
  - Character code constants: `CODE_C`=10 … `CODE_TIRE`=18, `CODE_BLANK`=19.
  - Active-low 7-bit segment constants for each glyph.
  - Digit count (4) and code width (5).
  - Shared with the lock FSM so both sides agree on codes.
- Sub-module `ssd_decode`: purely combinational 5-bit code → 7-bit active-low segments. Instantiated once and fed by the `idx` mux.

## Test plan
Bench parameters: `CLK_HZ=1000`, `REFRESH_HZ=50` (DWELL=5), `BLINK_HZ=10` (BLINK_HALF=50).
- Reset:
  - Hold `rst` low 3 cycles.
  - Required: `AN=1111`, `seven_out=7F`.
  - After release: `frame_start` pulses on the first edge, then `AN` cycles 0111,1011,1101,1110 with 5 cycles each.
- Decode:
  - Drive `ssd={10,11,12,13}` (CLSd).
  - Required over the frame: `seven_out` = 7'h31, 7'h71, 7'h24, 7'h42 in that order.
- Tearing:
  - Change `ssd` from `{14,15,16,17}` to `{1,2,3,4}` at `idx`=1 mid-frame.
  - Required: the remainder of the frame still shows P,E,n; the next frame shows 1,2,3,4.
- Blink (`SSD_BLINK_EN`):
  - `blink_mask=4'b1000` with `ssd={0,18,19,19}`.
  - Required: the leftmost digit shows 7'h01 for 50 cycles, then 7'h7F for 50 cycles, repeating.
  - Other digits are unaffected.
- Blink disabled build:
  - Same stimulus as the blink case.
  - Required: the leftmost digit always shows 7'h01.
- Mid-frame reset:
  - Assert `rst` at `idx`=2.
  - Required: `AN=1111` within the same cycle.
  - After release, the scan restarts at `AN=0111` with the blink phase on.
